// File: rtl/fetch_sequencer.sv
// fetch_sequencer: pc owner and IRAM fetch/decode sequencer.
// NOP/JUMP/HALT resolve locally; other opcodes go to the datapath.
module fetch_sequencer #(
  parameter int         ADDR_WIDTH   = 8,
  parameter int         IRAM_LATENCY = 1,
  parameter logic [3:0] OP_NOP       = 4'h0,
  parameter logic [3:0] OP_JUMP      = 4'hE,
  parameter logic [3:0] OP_HALT      = 4'hF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           instruction,
  input  logic [3:0]            cond_flags,
  input  logic                  execute_done,
  output logic [ADDR_WIDTH-1:0] iram_address,
  output logic                  iram_read,
  output logic                  load_instruction,
  output logic                  execute_start,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted
);

  localparam int LAT =
    (IRAM_LATENCY < 1) ? 1 : IRAM_LATENCY;
  localparam int CW =
    (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] WAIT_INIT =
    CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE =
    ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           wait_cnt;
  logic [CW-1:0]           wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pc_nxt;

  logic [3:0]              opcode;
  logic [3:0]              jcond;
  logic                    is_nop;
  logic                    is_jump;
  logic                    is_halt;
  logic                    jump_taken;
  logic [ADDR_WIDTH-1:0]   jump_target;
  logic [ADDR_WIDTH-1:0]   pc_inc;

  assign opcode      = instruction[15:12];
  assign jcond       = instruction[11:8];
  assign jump_target = ADDR_WIDTH'(instruction[7:0]);
  assign pc_inc      = pc_q + PC_ONE;

  assign is_nop  = (opcode == OP_NOP);
  assign is_jump = (opcode == OP_JUMP);
  assign is_halt = (opcode == OP_HALT);

  // a zero condition field means unconditional
  assign jump_taken =
    (jcond == 4'h0) || (|(jcond & cond_flags));

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt    = S_FETCH;
          pc_nxt       = '0;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      S_FETCH: begin
        if (wait_cnt == '0) begin
          state_nxt = S_LOAD;
        end else begin
          wait_cnt_nxt = wait_cnt - CNT_ONE;
        end
      end
      S_LOAD: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_halt: begin
            state_nxt = S_HALTED;
          end
          is_nop: begin
            state_nxt    = S_FETCH;
            pc_nxt       = pc_inc;
            wait_cnt_nxt = WAIT_INIT;
          end
          is_jump: begin
            state_nxt    = S_FETCH;
            pc_nxt       = jump_taken ?
                           jump_target : pc_inc;
            wait_cnt_nxt = WAIT_INIT;
          end
          default: begin
            state_nxt = S_EXEC;
          end
        endcase
      end
      S_EXEC: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (execute_done) begin
          state_nxt    = S_FETCH;
          pc_nxt       = pc_inc;
          wait_cnt_nxt = WAIT_INIT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // outputs decoded from next state so every strobe is a flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      pc_q             <= '0;
      wait_cnt         <= '0;
      iram_read        <= 1'b0;
      load_instruction <= 1'b0;
      execute_start    <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
    end else begin
      state            <= state_nxt;
      pc_q             <= pc_nxt;
      wait_cnt         <= wait_cnt_nxt;
      iram_read        <= (state_nxt == S_FETCH);
      load_instruction <= (state_nxt == S_LOAD);
      execute_start    <= (state_nxt == S_EXEC);
      busy             <= (state_nxt != S_IDLE) &&
                          (state_nxt != S_HALTED);
      halted           <= (state_nxt == S_HALTED);
    end
  end

  assign pc           = pc_q;
  assign iram_address = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: two lanes (IRAM latency 1 and 3), each with an
// instruction-level reference model plus directed literal checks.
module tb_fetch_sequencer;

  localparam int N = 40;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [15:0] iram [256];
  logic [1:0]  rst;
  logic [1:0]  st;
  logic [1:0]  done;
  logic [3:0]  cf     [2];
  logic [7:0]  o_addr [2];
  logic [7:0]  o_pc   [2];
  logic        o_rd   [2];
  logic        o_ld   [2];
  logic        o_ex   [2];
  logic        o_busy [2];
  logic        o_halt [2];

  logic        st_plan   [N];
  logic        done_plan [N];
  logic [3:0]  cf_plan   [N];
  logic [7:0]  tr_pc   [N];
  logic [7:0]  tr_addr [N];
  logic        tr_rd   [N];
  logic        tr_ld   [N];
  logic        tr_ex   [N];
  logic        tr_busy [N];
  logic        tr_halt [N];

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [15:0] ir;
    logic        m_act;
    logic        m_hlt;
    logic [7:0]  m_pc;
    int          m_t;
    logic [15:0] m_ins;
    logic        m_take;

    fetch_sequencer #(
      .ADDR_WIDTH(8),
      .IRAM_LATENCY(LAT)
    ) dut (
      .clock(clock),
      .reset(rst[g]),
      .start(st[g]),
      .instruction(ir),
      .cond_flags(cf[g]),
      .execute_done(done[g]),
      .iram_address(o_addr[g]),
      .iram_read(o_rd[g]),
      .load_instruction(o_ld[g]),
      .execute_start(o_ex[g]),
      .pc(o_pc[g]),
      .busy(o_busy[g]),
      .halted(o_halt[g])
    );

    // instruction register, edge-triggered on the load strobe
    always @(posedge o_ld[g]) ir <= iram[o_addr[g]];

    // model: m_t = cycles spent on the current instruction
    assign m_ins  = iram[m_pc];
    assign m_take = (m_ins[11:8] == 4'h0) ||
                    ((m_ins[11:8] & cf[g]) != 4'h0);

    always @(posedge clock or posedge rst[g]) begin
      if (rst[g]) begin
        m_act <= 1'b0;
        m_hlt <= 1'b0;
        m_pc  <= 8'h00;
        m_t   <= 0;
      end else if (!m_act) begin
        if (st[g]) begin
          m_act <= 1'b1;
          m_hlt <= 1'b0;
          m_pc  <= 8'h00;
          m_t   <= 0;
        end
      end else if (m_t == LAT + 1) begin
        case (m_ins[15:12])
          4'hF: begin
            m_act <= 1'b0;
            m_hlt <= 1'b1;
          end
          4'h0: begin
            m_pc <= m_pc + 8'd1;
            m_t  <= 0;
          end
          4'hE: begin
            m_pc <= m_take ? m_ins[7:0] : m_pc + 8'd1;
            m_t  <= 0;
          end
          default: m_t <= m_t + 1;
        endcase
      end else if (m_t > LAT + 2 && done[g]) begin
        m_pc <= m_pc + 8'd1;
        m_t  <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end

    always @(negedge clock) begin
      chk($sformatf("l%0d busy", g),
          8'(o_busy[g]), 8'(m_act));
      chk($sformatf("l%0d halted", g),
          8'(o_halt[g]), 8'(m_hlt));
      chk($sformatf("l%0d pc", g), o_pc[g], m_pc);
      chk($sformatf("l%0d addr", g), o_addr[g], m_pc);
      chk($sformatf("l%0d read", g), 8'(o_rd[g]),
          8'(m_act && (m_t < LAT)));
      chk($sformatf("l%0d load", g), 8'(o_ld[g]),
          8'(m_act && (m_t == LAT)));
      chk($sformatf("l%0d exec", g), 8'(o_ex[g]),
          8'(m_act && (m_t == LAT + 2)));
    end
  end

  task automatic clr_plan(input logic [3:0] c);
    for (int k = 0; k < N; k++) begin
      st_plan[k]   = 1'b0;
      done_plan[k] = 1'b0;
      cf_plan[k]   = c;
    end
  endtask

  // start in cycle 0, then record cycles 1..n
  task automatic run(input int ln, input int n);
    @(negedge clock);
    st[ln]   = 1'b1;
    done[ln] = done_plan[0];
    cf[ln]   = cf_plan[0];
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      tr_pc[k]   = o_pc[ln];
      tr_addr[k] = o_addr[ln];
      tr_rd[k]   = o_rd[ln];
      tr_ld[k]   = o_ld[ln];
      tr_ex[k]   = o_ex[ln];
      tr_busy[k] = o_busy[ln];
      tr_halt[k] = o_halt[ln];
      st[ln]     = st_plan[k];
      done[ln]   = done_plan[k];
      cf[ln]     = cf_plan[k];
    end
  endtask

  task automatic chk_zero(input string nm, input int ln);
    chk({nm, " pc"}, o_pc[ln], 8'h00);
    chk({nm, " addr"}, o_addr[ln], 8'h00);
    chk({nm, " read"}, 8'(o_rd[ln]), 8'h00);
    chk({nm, " load"}, 8'(o_ld[ln]), 8'h00);
    chk({nm, " exec"}, 8'(o_ex[ln]), 8'h00);
    chk({nm, " busy"}, 8'(o_busy[ln]), 8'h00);
    chk({nm, " halted"}, 8'(o_halt[ln]), 8'h00);
  endtask

  initial begin
    int cnt;
    int len;
    rst   = 2'b00;
    st    = 2'b00;
    done  = 2'b00;
    cf[0] = 4'h0;
    cf[1] = 4'h0;
    for (int i = 0; i < 256; i++) iram[i] = 16'hF000;
    #1 rst = 2'b11;
    @(negedge clock);
    @(negedge clock);
    chk_zero("reset", 0);
    rst[0] = 1'b0;

    // NOP then HALT
    iram[0] = 16'h0000;
    iram[1] = 16'hF000;
    clr_plan(4'h0);
    run(0, 8);
    cnt = 0;
    for (int k = 1; k <= 8; k++) cnt += int'(tr_ld[k]);
    chk("t1 load count", 8'(cnt), 8'd2);
    chk("t1 load c2", 8'(tr_ld[2]), 8'd1);
    chk("t1 load c5", 8'(tr_ld[5]), 8'd1);
    chk("t1 pc c4", tr_pc[4], 8'h01);
    chk("t1 halted c7", 8'(tr_halt[7]), 8'd1);
    chk("t1 pc c7", tr_pc[7], 8'h01);
    chk("t1 busy c7", 8'(tr_busy[7]), 8'd0);

    // executed op, done ignored in EXEC, accepted 3rd WAIT cycle
    iram[0] = 16'h1203;
    clr_plan(4'h0);
    done_plan[4] = 1'b1;
    done_plan[7] = 1'b1;
    run(0, 12);
    cnt = 0;
    for (int k = 1; k <= 12; k++) cnt += int'(tr_ex[k]);
    chk("t2 exec count", 8'(cnt), 8'd1);
    chk("t2 exec c4", 8'(tr_ex[4]), 8'd1);
    chk("t2 pc c6", tr_pc[6], 8'h00);
    chk("t2 pc c7", tr_pc[7], 8'h00);
    chk("t2 pc c8", tr_pc[8], 8'h01);
    chk("t2 addr c8", tr_addr[8], 8'h01);
    chk("t2 read c8", 8'(tr_rd[8]), 8'd1);
    chk("t2 halted c11", 8'(tr_halt[11]), 8'd1);

    // jumps with flags 0001
    iram[0]  = 16'hE10A;
    iram[10] = 16'hE214;
    iram[11] = 16'hE020;
    iram[32] = 16'hF000;
    clr_plan(4'b0001);
    run(0, 14);
    chk("t3 taken", tr_pc[4], 8'h0A);
    chk("t3 not taken", tr_pc[7], 8'h0B);
    chk("t3 uncond", tr_pc[10], 8'h20);
    chk("t3 halted", 8'(tr_halt[13]), 8'd1);
    chk("t3 halt pc", tr_pc[13], 8'h20);

    // NOP at 255 wraps to 0
    iram[0]   = 16'hE1FF;
    iram[255] = 16'h0000;
    iram[1]   = 16'hF000;
    clr_plan(4'b0001);
    for (int k = 7; k < N; k++) cf_plan[k] = 4'h0;
    run(0, 14);
    chk("t4 pc 255", tr_pc[4], 8'hFF);
    chk("t4 wrap pc", tr_pc[7], 8'h00);
    chk("t4 wrap addr", tr_addr[7], 8'h00);
    chk("t4 wrap read", 8'(tr_rd[7]), 8'd1);
    chk("t4 halt pc", tr_pc[13], 8'h01);

    // start while busy ignored; reset in WAIT
    iram[0] = 16'h0000;
    iram[1] = 16'h1203;
    iram[2] = 16'hF000;
    clr_plan(4'h0);
    st_plan[6] = 1'b1;
    run(0, 8);
    chk("t5 exec c7", 8'(tr_ex[7]), 8'd1);
    chk("t5 pc c7", tr_pc[7], 8'h01);
    chk("t5 busy c8", 8'(tr_busy[8]), 8'd1);
    chk("t5 pc c8", tr_pc[8], 8'h01);
    #2 rst[0] = 1'b1;
    #1 chk_zero("t5 rst wait", 0);
    @(negedge clock);
    rst[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t5 idle busy", 8'(o_busy[0]), 8'd0);
    chk("t5 idle read", 8'(o_rd[0]), 8'd0);
    clr_plan(4'h0);
    run(0, 2);
    chk("t5 load c2", 8'(tr_ld[2]), 8'd1);
    #2 rst[0] = 1'b1;
    #1 chk_zero("t5 rst load", 0);
    @(negedge clock);
    rst[0] = 1'b0;

    // lane 1: latency 3, restart from HALTED
    iram[0] = 16'h0000;
    iram[1] = 16'hF000;
    @(negedge clock);
    rst[1] = 1'b0;
    clr_plan(4'h0);
    st_plan[11] = 1'b1;
    run(1, 16);
    cnt = 0;
    len = 0;
    for (int k = 1; k <= 11; k++) begin
      cnt += int'(tr_ld[k]);
      if (tr_rd[k]) begin
        len++;
      end else if (len != 0) begin
        chk("t6 read run", 8'(len), 8'd3);
        len = 0;
      end
    end
    chk("t6 load count", 8'(cnt), 8'd2);
    chk("t6 read c1", 8'(tr_rd[1]), 8'd1);
    chk("t6 read c4", 8'(tr_rd[4]), 8'd0);
    chk("t6 halted c11", 8'(tr_halt[11]), 8'd1);
    chk("t6 pc c11", tr_pc[11], 8'h01);
    chk("t6 restart pc", tr_pc[12], 8'h00);
    chk("t6 restart read", 8'(tr_rd[12]), 8'd1);
    chk("t6 restart busy", 8'(tr_busy[12]), 8'd1);
    chk("t6 restart halted", 8'(tr_halt[12]), 8'd0);
    chk("t6 load c15", 8'(tr_ld[15]), 8'd1);

    @(negedge clock);
    @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and sequencing controller for the instruction register and instruction RAM.
- Owns the program counter and drives the IRAM address/read.
- Generates the `load_instruction` strobe that the instruction register captures on.
- Decodes the opcode to handle NOP, JUMP and HALT locally; hands every other opcode to the datapath via an execute_start/execute_done handshake.

Parameters:
- ADDR_WIDTH, 8, width of program counter and IRAM address.
- IRAM_LATENCY, 1, clock cycles from address presented to IRAM data valid (minimum 1).
- OP_NOP, 4'h0, opcode with no datapath action.
- OP_JUMP, 4'hE, conditional jump opcode.
- OP_HALT, 4'hF, halt opcode.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin execution at address 0; honoured only in IDLE or HALTED.
- instruction  input  16  instruction register output: [15:12] opcode, [11:8] jump condition, [7:0] jump address.
- cond_flags  input  4  datapath status flags used for jump conditions.
- execute_done  input  1  datapath finished current instruction.
- iram_address  output  ADDR_WIDTH  IRAM read address (= pc).
- iram_read  output  1  IRAM read enable.
- load_instruction  output  1  one-cycle registered pulse; instruction register captures on its rising edge.
- execute_start  output  1  one-cycle pulse: datapath executes current instruction.
- pc  output  ADDR_WIDTH  current program counter.
- busy  output  1  high in every state except IDLE and HALTED.
- halted  output  1  high in HALTED.

Behaviour:
- Outputs:
  - All outputs are registered and glitch-free; `load_instruction` must never glitch because the instruction register is edge-triggered on it.
  - Reset values: pc=0, iram_address=0, iram_read=0, load_instruction=0, execute_start=0, busy=0, halted=0, state=IDLE.
- States: IDLE, FETCH, LOAD, DECODE, EXEC, WAIT, HALTED.
- IDLE:
  - start=1 -> FETCH, pc=0.
- FETCH:
  - iram_read=1 and iram_address=pc held for IRAM_LATENCY cycles, tracked by an internal wait counter.
  - Then -> LOAD.
- LOAD:
  - load_instruction=1 for exactly one cycle; iram_read=0.
  - -> DECODE.
- DECODE (instruction valid):
  - opcode=OP_HALT -> HALTED; pc unchanged, so it points at the HALT.
  - opcode=OP_NOP -> pc=pc+1, FETCH.
  - opcode=OP_JUMP: taken = (instruction[11:8]==0) OR |(instruction[11:8] & cond_flags).
    - Taken -> pc=instruction[7:0] (zero-extended/truncated to ADDR_WIDTH).
    - Not taken -> pc=pc+1.
    - Both cases -> FETCH.
  - Any other opcode -> EXEC.
- EXEC:
  - execute_start=1 for one cycle.
  - execute_done is ignored in this cycle.
  - -> WAIT.
- WAIT:
  - Stays until execute_done=1.
  - Then pc=pc+1 -> FETCH.
  - No timeout.
- HALTED:
  - halted=1, busy=0.
  - start=1 -> pc=0, FETCH.
- Cycle counts:
  - NOP/JUMP instruction: IRAM_LATENCY+2 cycles.
  - Executed instruction: IRAM_LATENCY+3+N cycles, where N = WAIT cycles up to and including execute_done.
- pc arithmetic is modulo 2^ADDR_WIDTH: pc=255 increments to 0 with ADDR_WIDTH=8.
- start while busy is ignored.
- execute_done outside WAIT is ignored.
- Reset asserted in any state takes effect immediately (asynchronous): all outputs return to reset values and any in-flight load_instruction or execute_start pulse is cut.

Test Plan:
1. Reset then start with IRAM[0]=16'h0000, IRAM[1]=16'hF000, IRAM_LATENCY=1:
   - load_instruction pulses at cycles 2 and 5 after start.
   - pc goes 0 -> 1.
   - halted=1 with pc=1, busy=0.
2. IRAM[0]=16'h1203 with execute_done held 3 cycles after execute_start:
   - exactly one execute_start pulse.
   - execute_done asserted during EXEC is ignored.
   - pc=1 only after execute_done is sampled in WAIT.
   - next fetch addresses 1.
3. Jumps with cond_flags=4'b0001:
   - IRAM[0]=16'hE10A -> taken, pc=8'h0A.
   - IRAM[10]=16'hE214 -> not taken, pc=11.
   - IRAM[11]=16'hE020 -> unconditional, pc=8'h20.
4. pc=255 executing a NOP:
   - pc wraps to 0.
   - iram_address=0 on the next fetch.
5. Reset asserted during WAIT and during LOAD:
   - all outputs drop to 0 asynchronously, state=IDLE.
   - start pulses while busy are shown ignored.
6. IRAM_LATENCY=3:
   - iram_read held exactly 3 cycles per fetch.
   - load_instruction pulses once per instruction.
   - start in HALTED restarts fetch at address 0.
